univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 150 +++++++++++++++
 tb/tb_univ_shift_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, Johnson, load and clear.
// It also has a movement counter that wraps after WIDTH moves and pulses done.
package univ_shift_reg_pkg;
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_JOHN = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;
endpackage

// One register bit. The top level resolves the neighbour bits for the boundary
// cells, so every bit uses the same mux.
module univ_shift_cell
  import univ_shift_reg_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] i_mode,
  input  logic       i_d,
  input  logic       i_from_hi,
  input  logic       i_from_lo,
  output logic       o_q
);
  logic r_q;
  logic w_nxt;

  always_comb begin
    w_nxt = r_q;
    case (mode_e'(i_mode))
      MODE_HOLD:                     w_nxt = r_q;
      MODE_SHR, MODE_ROR, MODE_JOHN: w_nxt = i_from_hi;
      MODE_SHL, MODE_ROL:            w_nxt = i_from_lo;
      MODE_LOAD:                     w_nxt = i_d;
      MODE_CLR:                      w_nxt = 1'b0;
      default:                       w_nxt = r_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_q <= 1'b0;
    else     r_q <= w_nxt;
  end

  assign o_q = r_q;
endmodule

module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             so_r,
  output logic             so_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_from_hi;
  logic [WIDTH-1:0] w_from_lo;
  logic             w_hi_in;
  logic             w_lo_in;
  logic             w_move;
  logic             w_wrap;
  logic             w_zero;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  // Bit that enters the MSB on a right move, and the LSB on a left move.
  always_comb begin
    w_hi_in = sin_r;
    case (mode_e'(mode))
      MODE_ROR:  w_hi_in = w_q[0];
      MODE_JOHN: w_hi_in = ~w_q[0];
      default:   w_hi_in = sin_r;
    endcase
    w_lo_in = (mode_e'(mode) == MODE_ROL) ? w_q[WIDTH-1] : sin_l;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH-1) begin : g_msb
        assign w_from_hi[gi] = w_hi_in;
      end else begin : g_mid_hi
        assign w_from_hi[gi] = w_q[gi+1];
      end
      if (gi == 0) begin : g_lsb
        assign w_from_lo[gi] = w_lo_in;
      end else begin : g_mid_lo
        assign w_from_lo[gi] = w_q[gi-1];
      end

      univ_shift_cell u_cell (
        .clk       (clk),
        .clr       (clr),
        .i_mode    (mode),
        .i_d       (d[gi]),
        .i_from_hi (w_from_hi[gi]),
        .i_from_lo (w_from_lo[gi]),
        .o_q       (w_q[gi])
      );
    end
  endgenerate

  always_comb begin
    w_move = 1'b0;
    w_zero = 1'b0;
    case (mode_e'(mode))
      MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_JOHN: w_move = 1'b1;
      MODE_LOAD, MODE_CLR:                               w_zero = 1'b1;
      default: ;
    endcase
  end

  assign w_wrap = w_move && (r_cnt == CW'(WIDTH-1));

  // done is the registered wrap, so it is high for exactly the cycle after the wrapping edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_wrap;
      if (w_zero)      r_cnt <= '0;
      else if (w_wrap) r_cnt <= '0;
      else if (w_move) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign q     = w_q;
  assign q_bar = ~w_q;
  assign so_r  = w_q[0];
  assign so_l  = w_q[WIDTH-1];
  assign cnt   = r_cnt;
  assign done  = r_done;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=4): one task per scenario, inline checks.
module tb_univ_shift_reg;
  localparam int WIDTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             clr;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r, sin_l;
  logic [WIDTH-1:0] q, q_bar;
  logic             so_r, so_l;
  logic [CW-1:0]    cnt;
  logic             done;

  int checks   = 0;
  int failures = 0;

  univ_shift_reg #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .clr(clr), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
    .q(q), .q_bar(q_bar), .so_r(so_r), .so_l(so_l), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  // Apply one mode across a rising edge, then settle 1ns past the edge.
  task automatic step(input logic [2:0] m);
    mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; mode = 3'b000; d = '0; sin_r = 1'b0; sin_l = 1'b0;
    #12;
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL reset_q got=%b exp=0000", q); end
    checks++; if (q_bar !== 4'b1111) begin failures++; $display("FAIL reset_qbar got=%b exp=1111", q_bar); end
    checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if ({so_l, so_r} !== 2'b00) begin failures++; $display("FAIL reset_so got=%b exp=00", {so_l, so_r}); end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_load_rotate();
    logic [3:0] eq [4] = '{4'b1101, 4'b1110, 4'b0111, 4'b1011};
    logic [2:0] ec [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic       ed [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    d = 4'b1011;
    step(3'b011);
    checks++; if (q !== 4'b1011 || cnt !== 3'd0) begin failures++; $display("FAIL load q/cnt got=%b/%0d exp=1011/0", q, cnt); end
    for (int i = 0; i < 4; i++) begin
      step(3'b100);
      checks++; if (q !== eq[i]) begin failures++; $display("FAIL ror_q[%0d] got=%b exp=%b", i, q, eq[i]); end
      checks++; if (cnt !== ec[i]) begin failures++; $display("FAIL ror_cnt[%0d] got=%0d exp=%0d", i, cnt, ec[i]); end
      checks++; if (done !== ed[i]) begin failures++; $display("FAIL ror_done[%0d] got=%b exp=%b", i, done, ed[i]); end
      checks++; if (so_r !== eq[i][0] || so_l !== eq[i][3] || q_bar !== ~eq[i]) begin
        failures++; $display("FAIL ror_outs[%0d] so_r=%b so_l=%b qbar=%b for q=%b", i, so_r, so_l, q_bar, eq[i]);
      end
    end
  endtask

  task automatic test_serial_fill();
    logic [3:0] eq [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    step(3'b111);
    checks++; if (q !== 4'b0000 || cnt !== 3'd0 || done !== 1'b0) begin failures++; $display("FAIL sclr q/cnt/done got=%b/%0d/%b exp=0000/0/0", q, cnt, done); end
    sin_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(3'b001);
      checks++; if (q !== eq[i]) begin failures++; $display("FAIL fill_q[%0d] got=%b exp=%b", i, q, eq[i]); end
    end
    checks++; if (so_r !== 1'b1) begin failures++; $display("FAIL fill_so_r got=%b exp=1", so_r); end
    checks++; if (done !== 1'b1 || cnt !== 3'd0) begin failures++; $display("FAIL fill_wrap done/cnt got=%b/%0d exp=1/0", done, cnt); end
    sin_r = 1'b0;
  endtask

  task automatic test_johnson();
    logic [3:0] eq [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic       ed [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    step(3'b111);
    for (int i = 0; i < 8; i++) begin
      step(3'b110);
      checks++; if (q !== eq[i]) begin failures++; $display("FAIL john_q[%0d] got=%b exp=%b", i, q, eq[i]); end
      checks++; if (done !== ed[i]) begin failures++; $display("FAIL john_done[%0d] got=%b exp=%b", i, done, ed[i]); end
      checks++; if (cnt !== 3'((i + 1) % 4)) begin failures++; $display("FAIL john_cnt[%0d] got=%0d exp=%0d", i, cnt, (i + 1) % 4); end
    end
  endtask

  task automatic test_async_reset();
    d = 4'b1001;
    step(3'b011);
    step(3'b100);
    step(3'b100);
    checks++; if (q !== 4'b0110 || cnt !== 3'd2) begin failures++; $display("FAIL pre_clr q/cnt got=%b/%0d exp=0110/2", q, cnt); end
    #2;
    clr = 1'b1;
    #1;
    checks++; if (q !== 4'b0000 || q_bar !== 4'b1111) begin failures++; $display("FAIL aclr q/qbar got=%b/%b exp=0000/1111", q, q_bar); end
    checks++; if (cnt !== 3'd0 || done !== 1'b0) begin failures++; $display("FAIL aclr cnt/done got=%0d/%b exp=0/0", cnt, done); end
    #1;
    clr = 1'b0;
    // First edge after release executes the sampled mode; the old count is gone.
    step(3'b100);
    checks++; if (q !== 4'b0000 || cnt !== 3'd1) begin failures++; $display("FAIL post_clr q/cnt got=%b/%0d exp=0000/1", q, cnt); end
    d = 4'b0011;
    step(3'b011);
    checks++; if (q !== 4'b0011 || cnt !== 3'd0) begin failures++; $display("FAIL post_clr_load q/cnt got=%b/%0d exp=0011/0", q, cnt); end
  endtask

  task automatic test_load_wrap();
    d = 4'b0000;
    step(3'b011);
    for (int i = 0; i < 3; i++) step(3'b001);
    checks++; if (cnt !== 3'd3) begin failures++; $display("FAIL wrap_setup cnt got=%0d exp=3", cnt); end
    d = 4'b0101;
    step(3'b011);
    checks++; if (q !== 4'b0101 || cnt !== 3'd0 || done !== 1'b0) begin failures++; $display("FAIL load_at_wrap q/cnt/done got=%b/%0d/%b exp=0101/0/0", q, cnt, done); end
    for (int i = 0; i < 3; i++) step(3'b101);
    step(3'b000);
    checks++; if (q !== 4'b1010 || cnt !== 3'd3 || done !== 1'b0) begin failures++; $display("FAIL hold_at_wrap q/cnt/done got=%b/%0d/%b exp=1010/3/0", q, cnt, done); end
    step(3'b111);
    checks++; if (q !== 4'b0000 || cnt !== 3'd0 || done !== 1'b0) begin failures++; $display("FAIL clr_at_wrap q/cnt/done got=%b/%0d/%b exp=0000/0/0", q, cnt, done); end
  endtask

  task automatic test_shift_left_hold();
    d = 4'b1001;
    step(3'b011);
    sin_l = 1'b1;
    step(3'b010);
    checks++; if (q !== 4'b0011 || cnt !== 3'd1) begin failures++; $display("FAIL shl1 q/cnt got=%b/%0d exp=0011/1", q, cnt); end
    sin_l = 1'b0;
    step(3'b010);
    checks++; if (q !== 4'b0110 || cnt !== 3'd2) begin failures++; $display("FAIL shl2 q/cnt got=%b/%0d exp=0110/2", q, cnt); end
    for (int i = 0; i < 3; i++) begin
      d = 4'b1111; sin_l = 1'b1; sin_r = 1'b1;
      step(3'b000);
      checks++; if (q !== 4'b0110 || cnt !== 3'd2 || done !== 1'b0) begin failures++; $display("FAIL hold[%0d] q/cnt/done got=%b/%0d/%b exp=0110/2/0", i, q, cnt, done); end
    end
    sin_l = 1'b0; sin_r = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] eq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    d = 4'b1000;
    step(3'b011);
    for (int i = 0; i < 5; i++) begin
      step(3'b101);
      checks++; if (q !== eq[i] || done !== ed[i]) begin failures++; $display("FAIL rol[%0d] q/done got=%b/%b exp=%b/%b", i, q, done, eq[i], ed[i]); end
    end
    checks++; if (cnt !== 3'd1) begin failures++; $display("FAIL rol_cnt got=%0d exp=1", cnt); end
  endtask

  initial begin
    test_reset();
    test_load_rotate();
    test_serial_fill();
    test_johnson();
    test_async_reset();
    test_load_wrap();
    test_shift_left_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
